// File: rtl/cmlk_3d_frame_pack_ctrl.sv
// Frame sequencer: one header word, then LINES x PIX_PER_LINE 16-bit samples packed two per 32-bit word.
// Sample-to-word latency 1 clk; a stalled output word holds din_rdy low and is kept stable.
module cmlk_3d_frame_pack_ctrl #(
   parameter int          PIX_PER_LINE = 640,
   parameter int          LINES        = 480,
   parameter logic [15:0] HDR_TAG      = 16'hC3D0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] din,
   input  logic        din_vld,
   output logic        din_rdy,
   output logic [31:0] m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        m_last,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic        err_drop
);

   localparam logic [11:0] PIX_MAX  = 12'(PIX_PER_LINE - 1);
   localparam logic [11:0] LINE_MAX = 12'(LINES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [11:0] r_pix;
   logic [11:0] r_line;
   logic [15:0] r_half;
   logic [31:0] r_data;
   logic        r_valid;
   logic        r_last;
   logic [15:0] r_frame_cnt;
   logic        r_err_drop;

   logic        w_din_rdy;
   logic        w_arm;
   logic        w_fin;
   logic        w_acc;
   logic        w_pix_end;
   logic        w_line_end;
   logic        w_emit;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_din_rdy   = 1'b0;
      w_arm       = 1'b0;
      w_fin       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_arm       = 1'b1;
               w_state_nxt = ST_HDR;
            end
         end
         ST_HDR: begin
            if (r_valid && m_ready) begin
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            // Once the frame's last word is loaded, no further samples belong to this frame.
            w_din_rdy = ~r_last & (~r_valid | m_ready);
            if (r_valid && r_last && m_ready) begin
               w_fin       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_acc      = din_vld & w_din_rdy;
   assign w_pix_end  = (r_pix == PIX_MAX);
   assign w_line_end = (r_line == LINE_MAX);
   // Odd samples complete a word; a line ending on an even sample flushes a padded word.
   assign w_emit     = w_acc & (r_pix[0] | w_pix_end);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pix       <= 12'd0;
         r_line      <= 12'd0;
         r_half      <= 16'h0000;
         r_data      <= 32'h0000_0000;
         r_valid     <= 1'b0;
         r_last      <= 1'b0;
         r_frame_cnt <= 16'h0000;
         r_err_drop  <= 1'b0;
      end else begin
         if (w_arm) begin
            r_data  <= {HDR_TAG, r_frame_cnt};
            r_valid <= 1'b1;
            r_last  <= 1'b0;
            r_pix   <= 12'd0;
            r_line  <= 12'd0;
            r_half  <= 16'h0000;
         end else begin
            if (w_emit) begin
               r_data  <= r_pix[0] ? {r_half, din} : {r_half | din, 16'h0000};
               r_valid <= 1'b1;
               r_last  <= w_pix_end & w_line_end;
            end else if (r_valid && m_ready) begin
               r_valid <= 1'b0;
               r_last  <= 1'b0;
            end
            if (w_acc) begin
               if (w_pix_end) begin
                  r_pix  <= 12'd0;
                  r_line <= w_line_end ? 12'd0 : r_line + 12'd1;
               end else begin
                  r_pix  <= r_pix + 12'd1;
               end
               r_half <= w_emit ? 16'h0000 : din;
            end
         end

         if (w_fin) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end

         if (w_arm) begin
            r_err_drop <= 1'b0;
         end else if (r_state == ST_IDLE && din_vld) begin
            r_err_drop <= 1'b1;
         end
      end
   end

   assign din_rdy   = w_din_rdy;
   assign m_data    = r_data;
   assign m_valid   = r_valid;
   assign m_last    = r_last;
   assign busy      = (r_state != ST_IDLE);
   assign frame_cnt = r_frame_cnt;
   assign err_drop  = r_err_drop;

endmodule
